// File: rtl/ddr_traffic_gen.sv
// Write-traffic source for the MIG user-interface domain: waits for calibration and a
// settle interval, then issues NUM_WORDS pattern words over a valid/ready handshake.
module ddr_traffic_gen #(
    parameter int unsigned       DATA_W        = 128,
    parameter int unsigned       NUM_WORDS     = 500,
    parameter int unsigned       CNT_W         = 16,
    parameter int unsigned       SETTLE_CYCLES = 127,
    parameter int unsigned       BURST_LEN     = 0,
    parameter int unsigned       GAP_LEN       = 2,
    parameter logic [31:0]       LFSR_SEED     = 32'h0000_0001,
    parameter logic [DATA_W-1:0] CONST_PAT     = {(DATA_W/8){8'hA5}}
) (
    input  logic              ui_clk,
    input  logic              reset,
    input  logic              calib_done,
    input  logic [1:0]        mode,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              busy,
    output logic              done
);
    localparam int unsigned      LANES      = DATA_W / 32;
    localparam logic [2:0]       S_IDLE     = 3'd0;
    localparam logic [2:0]       S_SETTLE   = 3'd1;
    localparam logic [2:0]       S_RUN      = 3'd2;
    localparam logic [2:0]       S_GAP      = 3'd3;
    localparam logic [2:0]       S_DONE     = 3'd4;
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] BURST_CNT  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] GAP_CNT    = CNT_W'(GAP_LEN);
    localparam logic [15:0]      SETTLE_CNT = 16'(SETTLE_CYCLES);
    localparam logic             PACED      = (BURST_LEN != 0);
    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
    localparam logic [31:0]      LFSR_TAPS  = 32'h8020_0003;

    logic [2:0]        state_reg;
    logic [15:0]       settle_cnt_reg;
    logic [CNT_W-1:0]  burst_cnt_reg;
    logic [CNT_W-1:0]  gap_cnt_reg;
    logic [1:0]        mode_reg;
    logic [31:0]       lfsr_reg;
    logic [31:0]       lfsr_next;
    logic [CNT_W-1:0]  word_cnt_next;
    logic [CNT_W-1:0]  burst_cnt_next;
    logic              transfer;
    logic [DATA_W-1:0] lfsr_word_cur;
    logic [DATA_W-1:0] lfsr_word_next;
    logic [DATA_W-1:0] first_word;
    logic [DATA_W-1:0] next_word;

    assign lfsr_next      = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? LFSR_TAPS : 32'h0);
    assign transfer       = wr_en & wr_ready;
    assign word_cnt_next  = word_cnt + CNT_W'(1);
    assign burst_cnt_next = burst_cnt_reg + CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lfsr_word_cur[gi*32 +: 32]  = lfsr_reg;
            assign lfsr_word_next[gi*32 +: 32] = lfsr_next;
        end
    endgenerate

    // Word 1 uses the live mode input because it is latched on the same edge.
    always_comb begin
        first_word = CONST_PAT;
        case (mode)
            2'd0:    first_word = DATA_W'(1);
            2'd1:    first_word = lfsr_word_cur;
            2'd2:    first_word = DATA_W'(1);
            default: first_word = CONST_PAT;
        endcase
    end

    // Word k+1 after the transfer of word k; word_cnt_next equals k here.
    always_comb begin
        next_word = CONST_PAT;
        case (mode_reg)
            2'd0:    next_word = DATA_W'(word_cnt_next) + DATA_W'(1);
            2'd1:    next_word = lfsr_word_next;
            2'd2:    next_word = {dout[DATA_W-2:0], dout[DATA_W-1]};
            default: next_word = CONST_PAT;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            settle_cnt_reg <= '0;
            burst_cnt_reg  <= '0;
            gap_cnt_reg    <= '0;
            mode_reg       <= '0;
            lfsr_reg       <= LFSR_SEED;
            wr_en          <= 1'b0;
            dout           <= '0;
            word_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else if (state_reg != S_IDLE && !calib_done) begin
            // Losing calibration aborts the run, overriding any same-cycle transfer.
            state_reg      <= S_IDLE;
            settle_cnt_reg <= '0;
            burst_cnt_reg  <= '0;
            gap_cnt_reg    <= '0;
            lfsr_reg       <= LFSR_SEED;
            wr_en          <= 1'b0;
            dout           <= '0;
            word_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (calib_done) begin
                        state_reg      <= S_SETTLE;
                        settle_cnt_reg <= SETTLE_CNT;
                        busy           <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_reg != 16'd0) begin
                        settle_cnt_reg <= settle_cnt_reg - 16'd1;
                    end else begin
                        state_reg <= S_RUN;
                        mode_reg  <= mode;
                        dout      <= first_word;
                        wr_en     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (transfer) begin
                        word_cnt <= word_cnt_next;
                        lfsr_reg <= lfsr_next;
                        if (word_cnt_next == LAST_CNT) begin
                            state_reg <= S_DONE;
                            wr_en     <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            dout <= next_word;
                            if (PACED && burst_cnt_next == BURST_CNT) begin
                                state_reg     <= S_GAP;
                                wr_en         <= 1'b0;
                                burst_cnt_reg <= '0;
                                gap_cnt_reg   <= GAP_CNT;
                            end else begin
                                burst_cnt_reg <= burst_cnt_next;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_reg <= CNT_W'(1)) begin
                        state_reg   <= S_RUN;
                        gap_cnt_reg <= '0;
                        wr_en       <= 1'b1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - CNT_W'(1);
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state_reg <= S_IDLE;
                    wr_en     <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_traffic_gen.sv
// Bench for ddr_traffic_gen: an unpaced and a burst-paced instance share stimulus and are
// checked every cycle against a behavioural model that derives each word from its index.
module tb_ddr_traffic_gen;
    localparam int P_IDLE   = 0;
    localparam int P_SETTLE = 1;
    localparam int P_RUN    = 2;
    localparam int P_GAP    = 3;
    localparam int P_DONE   = 4;

    typedef struct {
        int          phase;
        int          settle_left;
        int          gap_left;
        int          burst;
        int          k;
        int          mode;
        int          cnt;
        logic        wr_en;
        logic        done;
        logic [127:0] dout;
    } mdl_t;

    logic         ui_clk = 1'b0;
    logic         reset;
    logic         calib_done;
    logic [1:0]   mode;
    logic         wr_ready;
    logic         rand_ready;
    logic         chk_en;

    logic         wr_en_m, busy_m, done_m;
    logic [127:0] dout_m;
    logic [15:0]  word_cnt_m;
    logic         wr_en_b, busy_b, done_b;
    logic [127:0] dout_b;
    logic [15:0]  word_cnt_b;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           sb_cnt   = 0;
    logic [31:0]  lfsr_tab [0:511];
    mdl_t         m_main;
    mdl_t         m_bst;

    always #5 ui_clk = ~ui_clk;

    ddr_traffic_gen #(
        .DATA_W(128), .NUM_WORDS(500), .CNT_W(16), .SETTLE_CYCLES(4),
        .BURST_LEN(0), .GAP_LEN(2), .LFSR_SEED(32'h0000_0001)
    ) u_main (
        .ui_clk(ui_clk), .reset(reset), .calib_done(calib_done), .mode(mode),
        .wr_ready(wr_ready), .wr_en(wr_en_m), .dout(dout_m), .word_cnt(word_cnt_m),
        .busy(busy_m), .done(done_m)
    );

    ddr_traffic_gen #(
        .DATA_W(128), .NUM_WORDS(10), .CNT_W(16), .SETTLE_CYCLES(4),
        .BURST_LEN(4), .GAP_LEN(2), .LFSR_SEED(32'h0000_0001)
    ) u_burst (
        .ui_clk(ui_clk), .reset(reset), .calib_done(calib_done), .mode(mode),
        .wr_ready(wr_ready), .wr_en(wr_en_b), .dout(dout_b), .word_cnt(word_cnt_b),
        .busy(busy_b), .done(done_b)
    );

    // Word k of a run, straight from the pattern definitions.
    function automatic logic [127:0] pattern(input int md, input int k);
        logic [127:0] one;
        one = 128'd1;
        case (md)
            0:       return 128'(k);
            1:       return {4{lfsr_tab[k]}};
            2:       return one << ((k - 1) % 128);
            default: return {16{8'hA5}};
        endcase
    endfunction

    // Outputs after one clock edge given the inputs sampled at that edge.
    function automatic mdl_t mdl_step(input mdl_t m, input int settle, input int n_words,
                                      input int burst_len, input int gap_len, input logic rst,
                                      input logic calib, input logic [1:0] md, input logic rdy);
        mdl_t r;
        r = m;
        if (rst || (m.phase != P_IDLE && !calib)) begin
            r.phase = P_IDLE; r.settle_left = 0; r.gap_left = 0; r.burst = 0;
            r.k = 0; r.cnt = 0; r.wr_en = 1'b0; r.done = 1'b0; r.dout = '0;
            if (rst) r.mode = 0;
        end else begin
            case (m.phase)
                P_IDLE: if (calib) begin r.phase = P_SETTLE; r.settle_left = settle; end
                P_SETTLE: begin
                    if (m.settle_left > 0) r.settle_left = m.settle_left - 1;
                    else begin
                        r.phase = P_RUN; r.mode = int'(md); r.k = 1;
                        r.wr_en = 1'b1; r.dout = pattern(int'(md), 1);
                    end
                end
                P_RUN: begin
                    if (rdy) begin
                        r.cnt = m.cnt + 1;
                        r.burst = m.burst + 1;
                        if (r.cnt == n_words) begin
                            r.phase = P_DONE; r.wr_en = 1'b0; r.done = 1'b1;
                        end else begin
                            r.k = m.k + 1;
                            r.dout = pattern(m.mode, r.k);
                            if (burst_len > 0 && r.burst == burst_len) begin
                                r.phase = P_GAP; r.wr_en = 1'b0; r.burst = 0; r.gap_left = gap_len;
                            end
                        end
                    end
                end
                P_GAP: begin
                    if (m.gap_left <= 1) begin r.phase = P_RUN; r.wr_en = 1'b1; end
                    else r.gap_left = m.gap_left - 1;
                end
                default: begin end
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic ok, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic cmp_inst(input string nm, input mdl_t m, input logic we, input logic dn,
                            input logic bs, input logic [15:0] wc, input logic [127:0] d);
        logic exp_busy;
        logic ok;
        exp_busy = (m.phase == P_SETTLE || m.phase == P_RUN || m.phase == P_GAP);
        ok = (we === m.wr_en) && (dn === m.done) && (bs === exp_busy) &&
             (wc === 16'(m.cnt)) && (d === m.dout);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s_cycle t=%0t: got wr_en=%b done=%b busy=%b cnt=%0d dout=%h expected wr_en=%b done=%b busy=%b cnt=%0d dout=%h",
                      nm, $time, we, dn, bs, wc, d, m.wr_en, m.done, exp_busy, m.cnt, m.dout);
    endtask

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    always @(posedge ui_clk) begin
        m_main <= mdl_step(m_main, 4, 500, 0, 2, reset, calib_done, mode, wr_ready);
        m_bst  <= mdl_step(m_bst, 4, 10, 4, 2, reset, calib_done, mode, wr_ready);
    end

    always @(negedge ui_clk) begin
        if (chk_en) begin
            cmp_inst("main", m_main, wr_en_m, done_m, busy_m, word_cnt_m, dout_m);
            cmp_inst("burst", m_bst, wr_en_b, done_b, busy_b, word_cnt_b, dout_b);
        end
    end

    // Accepted-word scoreboard for the unpaced instance: words arrive as 1..N in order.
    always @(posedge ui_clk) begin
        if (chk_en && !reset && calib_done && m_main.phase == P_RUN && wr_en_m && wr_ready) begin
            check("sb_word", dout_m == pattern(m_main.mode, sb_cnt + 1), dout_m,
                  pattern(m_main.mode, sb_cnt + 1));
            sb_cnt = sb_cnt + 1;
        end
        if (reset || m_main.phase == P_IDLE) sb_cnt = 0;
    end

    initial begin
        wr_ready = 1'b1;
        forever begin
            tick();
            wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        int n;
        logic [16:0] wpat;
        reset = 1'b1; calib_done = 1'b0; mode = 2'd0; rand_ready = 1'b0; chk_en = 1'b0;
        lfsr_tab[0] = 32'h0;
        lfsr_tab[1] = 32'h0000_0001;
        for (int i = 2; i < 512; i++)
            lfsr_tab[i] = (lfsr_tab[i-1] >> 1) ^ (lfsr_tab[i-1][0] ? 32'h8020_0003 : 32'h0);
        check("lfsr_model_w2", lfsr_tab[2] == 32'h8020_0003, 128'(lfsr_tab[2]), 128'h8020_0003);
        check("lfsr_model_w4", lfsr_tab[4] == 32'h6018_0001, 128'(lfsr_tab[4]), 128'h6018_0001);

        tick();
        chk_en = 1'b1;
        check("reset_outputs", {wr_en_m, busy_m, done_m, word_cnt_m, dout_m} == '0,
              {wr_en_m, busy_m, done_m, word_cnt_m, dout_m[107:0]}, 128'h0);
        calib_done = 1'b1;
        repeat (3) tick();
        check("reset_holds_idle", busy_m == 1'b0 && wr_en_m == 1'b0, {busy_m, wr_en_m}, 128'h0);

        // Run 1: INC, continuous ready.
        reset = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!wr_en_m && n < 50);
        check("settle_latency", n == 6, 128'(n), 128'd6);
        check("inc_first_word", dout_m == 128'd1, dout_m, 128'd1);
        wpat[16] = wr_en_b;
        for (int i = 15; i >= 0; i--) begin tick(); wpat[i] = wr_en_b; end
        check("burst_wr_en_pattern", wpat == 17'b11110011110011000, 128'(wpat),
              128'(17'b11110011110011000));
        n = 0;
        while (!done_m && n < 1000) begin tick(); n++; end
        check("inc_done", done_m == 1'b1, 128'(done_m), 128'd1);
        check("inc_final", word_cnt_m == 16'd500 && dout_m == 128'd500 && !wr_en_m,
              {wr_en_m, word_cnt_m, dout_m[63:0]}, {1'b0, 16'd500, 64'd500});
        check("inc_sb_count", sb_cnt == 500, 128'(sb_cnt), 128'd500);

        // Run 2: LFSR with random backpressure.
        calib_done = 1'b0;
        repeat (2) tick();
        mode = 2'd1; rand_ready = 1'b1; calib_done = 1'b1;
        n = 0;
        while (!wr_en_m && n < 50) begin tick(); n++; end
        check("lfsr_first_word", dout_m == {4{32'h0000_0001}}, dout_m, {4{32'h0000_0001}});
        n = 0;
        while (!done_m && n < 4000) begin tick(); n++; end
        check("lfsr_done", done_m == 1'b1 && word_cnt_m == 16'd500, {done_m, word_cnt_m}, {1'b1, 16'd500});
        check("lfsr_sb_count", sb_cnt == 500, 128'(sb_cnt), 128'd500);

        // Run 3: WALK1 wrap, then calibration loss mid-run.
        calib_done = 1'b0;
        repeat (2) tick();
        mode = 2'd2; rand_ready = 1'b0; calib_done = 1'b1;
        n = 0;
        while (word_cnt_m != 16'd128 && n < 700) begin tick(); n++; end
        check("walk1_word129", dout_m == 128'h1, dout_m, 128'h1);
        n = 0;
        while (word_cnt_m != 16'd199 && n < 700) begin tick(); n++; end
        check("walk1_word200", dout_m == (128'h1 << 71), dout_m, 128'h1 << 71);
        calib_done = 1'b0;
        tick();
        check("calib_drop", {wr_en_m, done_m, word_cnt_m, dout_m} == '0,
              {wr_en_m, done_m, word_cnt_m, dout_m[109:0]}, 128'h0);
        calib_done = 1'b1; mode = 2'd1;
        n = 0;
        do begin tick(); n++; end while (!wr_en_m && n < 50);
        check("restart_latency", n == 6, 128'(n), 128'd6);
        check("restart_seed", dout_m == {4{32'h0000_0001}}, dout_m, {4{32'h0000_0001}});
        repeat (50) tick();
        mode = 2'd3;
        repeat (20) tick();
        check("mode_ignored_midrun", dout_m == {4{lfsr_tab[71]}}, dout_m, {4{lfsr_tab[71]}});

        // Reset in RUN, then a CONST run and reset in DONE.
        reset = 1'b1;
        tick();
        check("reset_in_run", {wr_en_m, busy_m, done_m, word_cnt_m, dout_m} == '0,
              {wr_en_m, busy_m, done_m, word_cnt_m, dout_m[107:0]}, 128'h0);
        reset = 1'b0;
        n = 0;
        while (!done_m && n < 1000) begin tick(); n++; end
        check("const_done", done_m == 1'b1 && dout_m == {16{8'hA5}}, dout_m, {16{8'hA5}});
        reset = 1'b1;
        tick();
        check("reset_in_done", {wr_en_m, busy_m, done_m, word_cnt_m, dout_m} == '0,
              {wr_en_m, busy_m, done_m, word_cnt_m, dout_m[107:0]}, 128'h0);
        repeat (4) tick();
        check("reset_calib_idle", busy_m == 1'b0 && wr_en_m == 1'b0 && busy_b == 1'b0,
              {busy_m, wr_en_m, busy_b}, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ddr_traffic_gen.md
# ddr_traffic_gen

Parametrised write-traffic generator for the MIG user-interface clock domain. It waits for DDR calibration, then a settle interval, then emits a bounded sequence of data words selectable between four patterns. Words go out over a valid/ready write handshake with optional burst/gap pacing. It sits between the calibration status of the memory controller and the write side of the user-data FIFO in design_1, replacing hand-written bench counters with a synthesizable source usable on hardware.

## Interface
- DATA_W, 128: output word width; multiple of 32, ≥32.
- NUM_WORDS, 500: words issued per run; 1..2^CNT_W-1.
- CNT_W, 16: width of word/burst counters.
- SETTLE_CYCLES, 127: ui_clk cycles waited after calibration before first word; 0..65535.
- BURST_LEN, 0: accepted words per burst; 0 = unpaced (continuous).
- GAP_LEN, 2: idle cycles between bursts when BURST_LEN>0; ≥1.
- LFSR_SEED, 32'h0000_0001: LFSR initial state, nonzero.
- CONST_PAT, 128'hA5A5...A5: DATA_W-bit constant for mode 3.
- ui_clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- calib_done  in  1  memory controller calibration complete.
- mode  in  2  0=INC, 1=LFSR, 2=WALK1, 3=CONST; sampled on SETTLE→RUN.
- wr_ready  in  1  downstream can accept (e.g. ~fifo_full).
- wr_en  out  1  dout valid.
- dout  out  DATA_W  write data.
- word_cnt  out  CNT_W  words accepted this run.
- busy  out  1  state ∈ {SETTLE, RUN, GAP}.
- done  out  1  sticky: NUM_WORDS accepted.

## Operation
- Reset: already decided — reset reset, synchronous, active-high; clock ui_clk. On reset: state IDLE, wr_en=0, dout=0, word_cnt=0, busy=0, done=0, LFSR=LFSR_SEED, all counters 0.
- States: IDLE, SETTLE, RUN, GAP, DONE.
- IDLE: calib_done=1 → SETTLE, settle_cnt=SETTLE_CYCLES.
- SETTLE: settle_cnt≠0 → decrement; settle_cnt==0 → RUN, latch mode, register word 1 onto dout, wr_en=1.
- RUN: transfer = wr_en & wr_ready. On transfer: word_cnt+1, burst_cnt+1, next word registered. If word_cnt reaches NUM_WORDS → DONE, wr_en=0, done=1. Else if BURST_LEN>0 and burst_cnt reaches BURST_LEN → GAP, wr_en=0, burst_cnt=0, gap_cnt=GAP_LEN.
- GAP: gap_cnt decrements; at 1 → RUN, wr_en=1 (next word already on dout).
- DONE: wr_en=0, done held, dout holds last word. Exit only via reset or calib_done low.
- calib_done low in any non-IDLE state → IDLE next edge: wr_en=0, dout=0, word_cnt=0, done=0, burst/gap counters 0, LFSR reloaded with LFSR_SEED. Takes priority over a same-cycle transfer (that transfer is not counted).
- Pattern for word k (k=1..NUM_WORDS): INC: k zero-extended to DATA_W. LFSR: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1; word 1 = seed; advance once per transfer; state replicated DATA_W/32 times. WALK1: only bit ((k-1) mod DATA_W) set. CONST: CONST_PAT every word.
- Handshake: while wr_en=1 and wr_ready=0, dout and wr_en hold stable; no counter advances.
- mode changes outside SETTLE→RUN ignored.

## Timing
- calib_done sampled high at edge E0 → wr_en first high after edge E0+SETTLE_CYCLES+1.
- Registered outputs only; no combinational path from wr_ready to wr_en/dout.
- Back-to-back: with wr_ready held high in RUN, one word per cycle.
- Gap: exactly GAP_LEN cycles with wr_en=0 between last word of one burst and first of next.
- done rises on the edge accepting word NUM_WORDS; wr_en falls on the same edge.
- busy = 1 from the edge entering SETTLE until the edge entering DONE or IDLE.

## Test plan
- SETTLE_CYCLES=4, mode=0, NUM_WORDS=500, wr_ready=1: calib_done high at edge 0 → wr_en first high after edge 5, dout=1..500 on consecutive cycles, done=1 and word_cnt=500 after last, wr_en=0 afterwards.
- BURST_LEN=4, GAP_LEN=2, wr_ready=1, NUM_WORDS=10: wr_en pattern 1111 00 1111 00 11 then 0; dout 1..10 with no skips/repeats.
- Backpressure: wr_ready random 50%: dout stable while wr_en&~wr_ready; scoreboard sees exactly 1..NUM_WORDS once each.
- mode=1, seed 1: first word = 32'h00000001 ×4 lanes; subsequent words match reference Galois LFSR model; mode=2: word 129 = bit 0 set (wrap at DATA_W=128).
- calib_done drops at word 200 → next edge wr_en=0, word_cnt=0, done=0; re-assert → full settle then restart at word 1 / seed.
- reset asserted in RUN and in DONE → all outputs 0 next edge, state IDLE; reset high with calib_done high holds IDLE.
